// File: rtl/led_pattern_gen.sv
// LED pattern generator: rotates, bounces or blinks an LED_NUM-wide pattern once per
// programmable prescaler period, with runtime divider reload, pause and a step strobe.
module led_pattern_gen #(
    parameter int unsigned           LED_NUM     = 4,
    parameter int unsigned           CNT_W       = 24,
    parameter logic [CNT_W-1:0]      DEFAULT_DIV = CNT_W'(2499999),
    parameter logic [LED_NUM-1:0]    INIT_PAT    = LED_NUM'(1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         mode,
    input  logic               div_load,
    input  logic [CNT_W-1:0]   div_val,
    input  logic               pause,
    output logic [LED_NUM-1:0] led_sig,
    output logic               step_pulse
);

    typedef enum logic {DirLeft, DirRight} dir_e;

    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   div_q, div_d;
    logic [1:0]         mode_q, mode_d;
    logic [LED_NUM-1:0] led_q, led_d;
    dir_e               dir_q, dir_d;
    logic               step_q, step_d;

    logic mode_chg;
    assign mode_chg = (mode != mode_q);

    always_comb begin
        cnt_d  = cnt_q;
        div_d  = div_q;
        mode_d = mode_q;
        led_d  = led_q;
        dir_d  = dir_q;
        step_d = 1'b0;
        if (mode_chg || div_load) begin
            // Restart and reload are independent; both may apply on the same edge.
            cnt_d = '0;
            if (mode_chg) begin
                mode_d = mode;
                led_d  = INIT_PAT;
                dir_d  = DirLeft;
            end
            if (div_load) begin
                div_d = div_val;
            end
        end else if (pause) begin
            cnt_d = cnt_q;
        end else if (cnt_q == div_q) begin
            cnt_d  = '0;
            step_d = 1'b1;
            if (led_q == '0) begin
                led_d = INIT_PAT;
            end else begin
                case (mode_q)
                    2'b00: led_d = {led_q[LED_NUM-2:0], led_q[LED_NUM-1]};
                    2'b01: led_d = {led_q[0], led_q[LED_NUM-1:1]};
                    2'b10: begin
                        // Turn around at the ends so each endpoint is shown for one period.
                        if (dir_q == DirLeft && led_q[LED_NUM-1]) begin
                            dir_d = DirRight;
                            led_d = led_q >> 1;
                        end else if (dir_q == DirRight && led_q[0]) begin
                            dir_d = DirLeft;
                            led_d = led_q << 1;
                        end else if (dir_q == DirLeft) begin
                            led_d = led_q << 1;
                        end else begin
                            led_d = led_q >> 1;
                        end
                    end
                    default: led_d = ~led_q;
                endcase
            end
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            div_q  <= DEFAULT_DIV;
            mode_q <= 2'b00;
            led_q  <= INIT_PAT;
            dir_q  <= DirLeft;
            step_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            div_q  <= div_d;
            mode_q <= mode_d;
            led_q  <= led_d;
            dir_q  <= dir_d;
            step_q <= step_d;
        end
    end

    assign led_sig    = led_q;
    assign step_pulse = step_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen with LED_NUM=4, DEFAULT_DIV=3, INIT_PAT=0001.
module tb_led_pattern_gen;

    localparam int unsigned CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       mode;
    logic             div_load;
    logic [CNT_W-1:0] div_val;
    logic             pause;
    logic [3:0]       led_sig;
    logic             step_pulse;

    int n_total = 0;
    int n_bad   = 0;

    led_pattern_gen #(
        .LED_NUM    (4),
        .CNT_W      (CNT_W),
        .DEFAULT_DIV(8'd3),
        .INIT_PAT   (4'b0001)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .div_load  (div_load),
        .div_val   (div_val),
        .pause     (pause),
        .led_sig   (led_sig),
        .step_pulse(step_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one edge, then sample pattern and strobe.
    task automatic step_check(input string tag, input logic [3:0] exp_led, input logic exp_step);
        @(posedge clk);
        #1;
        check({tag, ".led"}, 32'(led_sig), 32'(exp_led));
        check({tag, ".step"}, 32'(step_pulse), 32'(exp_step));
    endtask

    // One full period of div_reg=3: three holds then an update with a strobe.
    task automatic period(input string tag, input logic [3:0] prev, input logic [3:0] next);
        for (int j = 0; j < 3; j++) step_check(tag, prev, 1'b0);
        step_check(tag, next, 1'b1);
    endtask

    initial begin
        rst      = 1'b1;
        mode     = 2'b00;
        div_load = 1'b0;
        div_val  = '0;
        pause    = 1'b0;
        #1;
        check("reset.led", 32'(led_sig), 32'h1);
        check("reset.step", 32'(step_pulse), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Rotate left from reset.
        period("rotl", 4'b0001, 4'b0010);
        period("rotl", 4'b0010, 4'b0100);
        period("rotl", 4'b0100, 4'b1000);
        period("rotl", 4'b1000, 4'b0001);
        period("rotl", 4'b0001, 4'b0010);

        // Mid-period switch to rotate right restarts at INIT_PAT without a strobe.
        step_check("pre_rotr", 4'b0010, 1'b0);
        step_check("pre_rotr", 4'b0010, 1'b0);
        mode = 2'b01;
        step_check("rotr_restart", 4'b0001, 1'b0);
        period("rotr", 4'b0001, 4'b1000);
        period("rotr", 4'b1000, 4'b0100);

        // Bounce.
        mode = 2'b10;
        step_check("bnc_restart", 4'b0001, 1'b0);
        period("bnc", 4'b0001, 4'b0010);
        period("bnc", 4'b0010, 4'b0100);
        period("bnc", 4'b0100, 4'b1000);
        period("bnc", 4'b1000, 4'b0100);
        period("bnc", 4'b0100, 4'b0010);
        period("bnc", 4'b0010, 4'b0001);
        period("bnc", 4'b0001, 4'b0010);

        // Blink.
        mode = 2'b11;
        step_check("blk_restart", 4'b0001, 1'b0);
        period("blk", 4'b0001, 4'b1110);
        period("blk", 4'b1110, 4'b0001);

        // Mode change and div_load=0 together, then a tick every clock.
        mode     = 2'b00;
        div_load = 1'b1;
        div_val  = 8'd0;
        step_check("ld0", 4'b0001, 1'b0);
        div_load = 1'b0;
        step_check("fast", 4'b0010, 1'b1);
        step_check("fast", 4'b0100, 1'b1);
        step_check("fast", 4'b1000, 1'b1);

        // Reload 3, run cnt up to 2, then pause for 5 cycles.
        div_load = 1'b1;
        div_val  = 8'd3;
        step_check("ld3", 4'b1000, 1'b0);
        div_load = 1'b0;
        step_check("cnt1", 4'b1000, 1'b0);
        step_check("cnt2", 4'b1000, 1'b0);
        pause = 1'b1;
        for (int i = 0; i < 5; i++) step_check("pause", 4'b1000, 1'b0);
        pause = 1'b0;
        step_check("resume1", 4'b1000, 1'b0);
        step_check("resume2", 4'b0001, 1'b1);
        step_check("resume3", 4'b0001, 1'b0);

        // Load 0, take one tick, then reset asynchronously while the strobe is high.
        div_load = 1'b1;
        div_val  = 8'd0;
        step_check("ld0b", 4'b0001, 1'b0);
        div_load = 1'b0;
        step_check("fastb", 4'b0010, 1'b1);
        rst = 1'b1;
        #1;
        check("async_rst.led", 32'(led_sig), 32'h1);
        check("async_rst.step", 32'(step_pulse), 32'h0);
        @(posedge clk);
        #1;
        check("rst_hold.led", 32'(led_sig), 32'h1);
        rst = 1'b0;
        // DEFAULT_DIV restored: first step on the fourth edge.
        period("post_rst", 4'b0001, 4'b0010);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/led_pattern_gen.md
Name: led_pattern_gen

Overview:
- Parametrised successor to the LED waterfall: drives an LED_NUM-wide pattern that advances once per programmable prescaler period.
- Four runtime-selectable modes: rotate left, rotate right, ping-pong bounce and blink.
- Supports runtime divider reload, pause, and a step strobe for downstream logic such as UART status reporting.
- Sits between board LEDs and control logic; it is a free-running peripheral.

Parameters:
- LED_NUM, 4: pattern width; must be ≥ 2.
- CNT_W, 24: prescaler counter and divider width.
- DEFAULT_DIV, 2499999: divider value after reset; period = DEFAULT_DIV+1 clocks.
- INIT_PAT, 4'b0001: pattern after reset, mode change, or all-zero recovery; must be one-hot for bounce mode.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- mode  in  2  00 rotate-left, 01 rotate-right, 10 bounce, 11 blink.
- div_load  in  1  single-cycle strobe; loads div_val into the divider register.
- div_val  in  CNT_W  new divider value.
- pause  in  1  level; freezes prescaler and pattern.
- led_sig  out  LED_NUM  registered LED pattern.
- step_pulse  out  1  registered; high for exactly 1 cycle on each pattern update.

Behaviour:
- Reset is asynchronous and active-high; it applies immediately with no clock edge required:
  - led_sig = INIT_PAT, step_pulse = 0, cnt = 0, div_reg = DEFAULT_DIV.
  - mode_q = 00, dir = left.
- Registered state: cnt[CNT_W-1:0], div_reg[CNT_W-1:0], mode_q[1:0], dir (0 = left, toward MSB).
- Per-edge priority, highest first:
  1. Mode change (mode != mode_q): mode_q <= mode, led_sig <= INIT_PAT, dir <= left, cnt <= 0, step_pulse <= 0. Counts as a restart; no step.
  2. div_load: div_reg <= div_val, cnt <= 0, step_pulse <= 0. If it coincides with a mode change, both the reload and the mode restart apply.
  3. pause = 1: cnt, led_sig and dir hold; step_pulse <= 0.
  4. Tick (cnt == div_reg): cnt <= 0, step_pulse <= 1, pattern updates per mode_q.
  5. Otherwise: cnt <= cnt + 1, step_pulse <= 0.
- Pattern update on a tick:
  - 00 rotate left: {led_sig[LED_NUM-2:0], led_sig[LED_NUM-1]}.
  - 01 rotate right: {led_sig[0], led_sig[LED_NUM-1:1]}.
  - 10 bounce:
    - dir = left and MSB set: dir <= right, shift right by 1.
    - dir = right and LSB set: dir <= left, shift left by 1.
    - Otherwise: shift one position in dir, zero fill.
    - Endpoints are shown for exactly one period.
  - 11 blink: led_sig <= ~led_sig.
- All-zero recovery: if led_sig == 0 at a tick (any mode), load INIT_PAT instead and still assert step_pulse.
- Timing:
  - div_reg = 0 gives a tick every clock.
  - After reset release, or after a mode change or div_load, the first update occurs on the (div_reg+1)-th subsequent edge.
  - step_pulse and the led_sig change occur on the same edge.
- Prescaler never wraps past div_reg. A div_load value below the current cnt cannot strand the counter, because cnt is cleared on load.
- Pause mid-period preserves cnt; on release the remaining count continues.
- rst asserted mid-operation aborts the current period; no partial step is emitted.

Test Plan (LED_NUM=4, DEFAULT_DIV=3, INIT_PAT=0001):
1. Release rst with mode=00 -> led_sig 0001, then 0010 at edge 4, 0100 at 8, 1000 at 12, 0001 at 16; step_pulse is a single-cycle pulse at edges 4, 8, 12, 16 only.
2. Switch mode to 01 mid-period -> led_sig = 0001 on the next edge with no step_pulse, then 1000 and 0100 at 4-cycle intervals.
3. mode=10 -> sequence 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010, each held 4 cycles.
4. mode=11 -> 0001, 1110, 0001; step_pulse on every toggle.
5. div_load with div_val=0 -> led_sig rotates every clock. Then pause high for 5 cycles with div_val=3 reloaded and cnt=2 -> led_sig frozen and no step_pulse; the next update arrives 2 cycles after pause drops.
6. Assert rst between clock edges mid-period -> led_sig = 0001 and step_pulse = 0 immediately. After release, div_reg = 3 (first step at edge 4) even if 0 was previously loaded.
